// File: rtl/cache_pkg.sv
// Shared types and constants for the 4-entry fully-associative read cache.
// The optional hit/miss statistics are enabled with CACHE_STATS_EN.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM_WAIT, DONE} state_t;

  localparam int          NUM_ENTRIES = 4;
  localparam int          IDX_W       = 2;
  localparam logic [1:0]  CNT_MAX     = 2'b11;

  typedef logic [NUM_ENTRIES-1:0][1:0] cnt_vec_t;

  // Selected entry becomes most recent; flagged others age by one, floored at 0.
  function automatic cnt_vec_t lru_update(input cnt_vec_t cnt,
                                          input logic [IDX_W-1:0] sel,
                                          input logic [NUM_ENTRIES-1:0] dec);
    cnt_vec_t res;
    res = cnt;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (IDX_W'(i) == sel) begin
        res[i] = CNT_MAX;
      end else if (dec[i] && (cnt[i] != 2'b00)) begin
        res[i] = cnt[i] - 2'b01;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_ctrl_determine_hit.sv
// Combinational tag match and victim/age selection for the cache entries.
// sel is the matching entry on a hit, else the first invalid or zero-count entry, else entry 3.
module determine_hit
  import cache_pkg::*;
#(
  parameter int a_width = 8
) (
  input  logic [a_width-1:0]                  addr,
  input  logic [NUM_ENTRIES-1:0][a_width-1:0] tag,
  input  cnt_vec_t                            cnt,
  input  logic [NUM_ENTRIES-1:0]              valid,
  output logic [IDX_W-1:0]                    sel,
  output logic [NUM_ENTRIES-1:0]              dec,
  output logic                                hit
);

  logic [NUM_ENTRIES-1:0] w_match;
  logic [NUM_ENTRIES-1:0] w_free;
  logic [IDX_W-1:0]       w_hit_idx;
  logic [IDX_W-1:0]       w_vic_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      assign w_match[gi] = valid[gi] && (tag[gi] == addr);
      assign w_free[gi]  = !valid[gi] || (cnt[gi] == 2'b00);
      // Every other live entry ages when one is touched.
      assign dec[gi]     = valid[gi] && (sel != IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    w_hit_idx = '0;
    w_vic_idx = IDX_W'(NUM_ENTRIES - 1);
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (w_match[i]) w_hit_idx = IDX_W'(i);
      if (w_free[i])  w_vic_idx = IDX_W'(i);
    end
  end

  assign hit = |w_match;
  assign sel = hit ? w_hit_idx : w_vic_idx;

endmodule

// File: rtl/cache_ctrl.sv
// Read-only 4-entry fully-associative cache controller with LRU-count replacement.
// Define CACHE_STATS_EN to add the hit_count/miss_count statistics ports.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int d_width = 8,
  parameter int a_width = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic [a_width-1:0] addr,
  input  logic               flush,
  output logic [d_width-1:0] rdata,
  output logic               ready,
  output logic               mem_req,
  output logic [a_width-1:0] mem_addr,
  input  logic [d_width-1:0] mem_rdata,
  input  logic               mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count
`endif
);

  state_t                              r_state;
  logic [a_width-1:0]                  r_addr_q;
  logic [IDX_W-1:0]                    r_sel_q;
  logic [NUM_ENTRIES-1:0]              r_dec_q;
  logic [NUM_ENTRIES-1:0][a_width-1:0] r_tag;
  logic [NUM_ENTRIES-1:0][d_width-1:0] r_data;
  cnt_vec_t                            r_cnt;
  logic [NUM_ENTRIES-1:0]              r_valid;

  logic [IDX_W-1:0]                    w_sel;
  logic [NUM_ENTRIES-1:0]              w_dec;
  logic                                w_hit;

  determine_hit #(
    .a_width(a_width)
  ) u_determine_hit (
    .addr (r_addr_q),
    .tag  (r_tag),
    .cnt  (r_cnt),
    .valid(r_valid),
    .sel  (w_sel),
    .dec  (w_dec),
    .hit  (w_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr_q   <= '0;
      r_sel_q    <= '0;
      r_dec_q    <= '0;
      r_tag      <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_valid    <= '0;
      rdata      <= '0;
      ready      <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
`ifdef CACHE_STATS_EN
      hit_count  <= '0;
      miss_count <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (flush) begin
            r_valid <= '0;
            r_cnt   <= '0;
          end else if (req) begin
            r_addr_q <= addr;
            r_state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_sel_q <= w_sel;
          r_dec_q <= w_dec;
          if (w_hit) begin
            rdata   <= r_data[w_sel];
            r_cnt   <= lru_update(r_cnt, w_sel, w_dec);
            ready   <= 1'b1;
            r_state <= DONE;
`ifdef CACHE_STATS_EN
            hit_count <= hit_count + 16'd1;
`endif
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= r_addr_q;
            r_state  <= MEM_WAIT;
`ifdef CACHE_STATS_EN
            miss_count <= miss_count + 16'd1;
`endif
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            r_tag[r_sel_q]   <= r_addr_q;
            r_data[r_sel_q]  <= mem_rdata;
            r_valid[r_sel_q] <= 1'b1;
            r_cnt            <= lru_update(r_cnt, r_sel_q, r_dec_q);
            rdata            <= mem_rdata;
            mem_req          <= 1'b0;
            ready            <= 1'b1;
            r_state          <= DONE;
          end
        end
        DONE: begin
          ready   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
